// File: rtl/pia_uart_ctrl.sv
// Apple 1 PIA register front-end for the shared USB UART.
// RX/TX FIFOs replace the keyboard/display latches at D010-D013.
module pia_uart_ctrl #(
  parameter int RX_DEPTH  = 4,
  parameter int TX_DEPTH  = 4,
  parameter int RX_HIWAT  = 3,
  parameter int START_TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_stb,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       uart_received,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_is_receiving,
  input  logic       uart_is_transmitting,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  output logic       uart_cts
);

  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int TMW = $clog2(START_TMO + 1);

  localparam logic [RCW-1:0] RX_FULL_N = RCW'(RX_DEPTH);
  localparam logic [RCW-1:0] RX_HI_N   = RCW'(RX_HIWAT);
  localparam logic [TCW-1:0] TX_FULL_N = TCW'(TX_DEPTH);
  localparam logic [TMW-1:0] TMO_LAST  = TMW'(START_TMO - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } tx_state_e;

  logic acc, rd, wr;
  logic rd0, rd1, rd2;
  logic rx_flush, tx_flush;

  assign acc = cpu_stb & cs;
  assign rd  = acc & rw;
  assign wr  = acc & ~rw;
  assign rd0 = rd & (addr == 2'd0);
  assign rd1 = rd & (addr == 2'd1);
  assign rd2 = rd & (addr == 2'd2);
  assign rx_flush = wr & (addr == 2'd3) & wdata[0];
  assign tx_flush = wr & (addr == 2'd3) & wdata[1];

  // RX FIFO
  logic [6:0]     rx_mem_q [RX_DEPTH];
  logic [RPW-1:0] rx_wptr_q, rx_wptr_d;
  logic [RPW-1:0] rx_rptr_q, rx_rptr_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           rx_ovf_q, rx_ovf_d;
  logic           rx_empty, rx_full;
  logic           rx_pop, rx_push, rx_drop;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_N);
  assign rx_pop   = rd0 & ~rx_empty;
  assign rx_push  = uart_received & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_drop  = uart_received & rx_full & ~rx_pop & ~rx_flush;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    rx_ovf_d  = rx_drop | (rx_ovf_q & ~rd1);
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      rx_wptr_d = rx_wptr_q + RPW'(rx_push);
      rx_rptr_d = rx_rptr_q + RPW'(rx_pop);
      rx_cnt_d  = rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_byte[6:0];
  end

  assign uart_cts = uart_is_receiving | (rx_cnt_q >= RX_HI_N);

  // TX FIFO
  logic [6:0]     tx_mem_q [TX_DEPTH];
  logic [TPW-1:0] tx_wptr_q, tx_wptr_d;
  logic [TPW-1:0] tx_rptr_q, tx_rptr_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic           tx_ovf_q, tx_ovf_d;
  logic           tx_empty, tx_full;
  logic           tx_wr, tx_push, tx_drop, tx_pop;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_FULL_N);
  assign tx_wr    = wr & (addr == 2'd2);
  assign tx_push  = tx_wr & ~tx_full;
  assign tx_drop  = tx_wr & tx_full;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_ovf_d  = tx_drop | (tx_ovf_q & ~rd2);
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      tx_wptr_d = tx_wptr_q + TPW'(tx_push);
      tx_rptr_d = tx_rptr_q + TPW'(tx_pop);
      tx_cnt_d  = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[6:0];
  end

  // TX sequencer; the byte is latched at the pulse so a flush cannot abort it
  tx_state_e      st_q, st_d;
  logic [TMW-1:0] tmr_q, tmr_d;
  logic           xmit_q, xmit_d;
  logic [7:0]     txb_q, txb_d;

  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q;
    xmit_d = 1'b0;
    txb_d  = txb_q;
    tx_pop = 1'b0;
    unique case (st_q)
      IDLE: begin
        tmr_d = '0;
        if (~tx_empty & ~uart_is_transmitting) begin
          xmit_d = 1'b1;
          txb_d  = {1'b0, tx_mem_q[tx_rptr_q]};
          tx_pop = 1'b1;
          st_d   = START;
        end
      end
      START: begin
        if (uart_is_transmitting) begin
          st_d = BUSY;
        end else if (tmr_q == TMO_LAST) begin
          st_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMW'(1);
        end
      end
      BUSY: begin
        if (~uart_is_transmitting) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // CPU read mux
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      unique case (addr)
        2'd0: rdata_d = rx_empty ? 8'h00
                      : {1'b1, rx_mem_q[rx_rptr_q]};
        2'd1: rdata_d = {~rx_empty, rx_ovf_q, 6'b0};
        2'd2: rdata_d = {tx_full, tx_ovf_q, 6'b0};
        2'd3: rdata_d = {6'b0, ~tx_empty, ~rx_empty};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      st_q      <= IDLE;
      tmr_q     <= '0;
      xmit_q    <= 1'b0;
      txb_q     <= 8'h00;
      rdata_q   <= 8'h00;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      st_q      <= st_d;
      tmr_q     <= tmr_d;
      xmit_q    <= xmit_d;
      txb_q     <= txb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata         = rdata_q;
  assign uart_transmit = xmit_q;
  assign uart_tx_byte  = txb_q;

endmodule
